// File: rtl/compare_sweep_checker_if.sv
// Bus between the compare sweep checker and its environment: start, compare pins, results.
interface compare_sweep_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 9
);
  logic             start;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [3:0]       cmp_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] fail_a;
  logic [WIDTH-1:0] fail_b;
  logic             fail_seen;

  // Environment side: issues start, supplies the compare result, observes results.
  modport master (
    output start, cmp_out,
    input  cmp_a, cmp_b, busy, done, pass, err_count, fail_a, fail_b, fail_seen
  );

  // Checker side.
  modport slave (
    input  start, cmp_out,
    output cmp_a, cmp_b, busy, done, pass, err_count, fail_a, fail_b, fail_seen
  );
endinterface

// File: rtl/compare_sweep_checker.sv
// Sequential self-test driver/checker for the 4-bit compare unit. Sweeps every (a,b) pair,
// waits SETTLE_CYCLES, checks cmp_out against {0, a>b, a<b, a==b}, counts mismatches and
// captures the first failing pair.
// Optional: define COMPARE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch and
// leave the failing pair on cmp_a/cmp_b.
// The bus interface must be instantiated with the same WIDTH/ERR_W as this module.
module compare_sweep_checker #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 2,  // 1..15
  parameter int unsigned ERR_W         = 9
) (
  input logic                    clk,
  input logic                    rst,
  compare_sweep_checker_if.slave bus
);

  localparam int unsigned PairW      = 2 * WIDTH;
  localparam logic [3:0]  SettleLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StFinish} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d;
  logic             fail_seen_q, fail_seen_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       settle_q, settle_d;

  logic [3:0]       expected;
  logic             mismatch;
  logic             last_pair;

  // Reference code from the registered operands, and end-of-sweep detection.
  always_comb begin
    expected  = {1'b0, a_q > b_q, a_q < b_q, a_q == b_q};
    mismatch  = (bus.cmp_out != expected);
    last_pair = (&a_q) & (&b_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StDrive;
      StDrive:  state_d = StSettle;
      StSettle: if (settle_q == 4'd0) state_d = StCheck;
      StCheck: begin
`ifdef COMPARE_SWEEP_STOP_ON_FAIL_EN
        if (last_pair || mismatch) state_d = StFinish;
        else                       state_d = StDrive;
`else
        if (last_pair) state_d = StFinish;
        else           state_d = StDrive;
`endif
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.busy = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
    bus.done = (state_q == StFinish);
  end

  // Datapath next-state: operand sweep, settle timer, error bookkeeping.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    fail_seen_d = fail_seen_q;
    pass_d      = pass_q;
    err_d       = err_q;
    settle_d    = settle_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d         = '0;
          b_d         = '0;
          fail_a_d    = '0;
          fail_b_d    = '0;
          fail_seen_d = 1'b0;
          pass_d      = 1'b0;
          err_d       = '0;
        end
      end
      StDrive:  settle_d = SettleLoad;
      StSettle: if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          if (!fail_seen_q) begin
            fail_a_d    = a_q;
            fail_b_d    = b_q;
            fail_seen_d = 1'b1;
          end
        end
        // b is the low half, so a single increment carries into a when b wraps.
`ifdef COMPARE_SWEEP_STOP_ON_FAIL_EN
        if (!last_pair && !mismatch) {a_d, b_d} = {a_q, b_q} + PairW'(1);
`else
        if (!last_pair) {a_d, b_d} = {a_q, b_q} + PairW'(1);
`endif
        // pass must already be valid while done is high.
        if (state_d == StFinish) pass_d = (err_d == '0);
      end
      StFinish: ;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_seen_q <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      settle_q    <= 4'd0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
      fail_seen_q <= fail_seen_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      settle_q    <= settle_d;
    end
  end

  assign bus.cmp_a     = a_q;
  assign bus.cmp_b     = b_q;
  assign bus.fail_a    = fail_a_q;
  assign bus.fail_b    = fail_b_q;
  assign bus.fail_seen = fail_seen_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_compare_sweep_checker.sv
// Directed bench for compare_sweep_checker: table of full sweeps against a compare model
// with selectable faults, plus reset, busy-start and done-adjacent start sequences.
module tb_compare_sweep_checker;

`ifdef COMPARE_SWEEP_STOP_ON_FAIL_EN
  localparam bit Stop = 1'b1;
`else
  localparam bit Stop = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_sweep_checker_if #(.WIDTH(4), .ERR_W(9)) mif ();
  compare_sweep_checker_if #(.WIDTH(4), .ERR_W(3)) sif ();

  compare_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(2), .ERR_W(9)) u_dut (
    .clk(clk), .rst(rst), .bus(mif)
  );

  // Narrow counter instance fed an always-wrong result to exercise saturation.
  compare_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(2), .ERR_W(3)) u_sat (
    .clk(clk), .rst(rst), .bus(sif)
  );

  // Compare model: 0 correct, 1 eq stuck at 0, 2 one pair returns fbad.
  int         fault_kind = 0;
  logic [3:0] fpa = 4'd0, fpb = 4'd0, fbad = 4'd0;

  always_comb begin
    mif.cmp_out = {1'b0, mif.cmp_a > mif.cmp_b, mif.cmp_a < mif.cmp_b, mif.cmp_a == mif.cmp_b};
    if (fault_kind == 1) mif.cmp_out[0] = 1'b0;
    else if (fault_kind == 2 && mif.cmp_a == fpa && mif.cmp_b == fpb) mif.cmp_out = fbad;
    sif.start   = mif.start;
    sif.cmp_out = 4'b1000;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int kind; int fa; int fb; int bad;
    int exp_err; int exp_seen; int exp_fa; int exp_fb; int exp_pass;
    int exp_cycles; int exp_end_a; int exp_end_b; bit inj;
  } vec_t;

  // Expected outcome from the fault location; a stop-on-fail sweep ends at pair p after 4p+6.
  function automatic vec_t mk(input int kind, input int fa, input int fb, input int bad,
                              input int err_full, input bit inj);
    vec_t v;
    int   p;
    v.kind = kind; v.fa = fa; v.fb = fb; v.bad = bad; v.inj = inj;
    if (kind == 0) begin
      v.exp_err = 0; v.exp_seen = 0; v.exp_fa = 0; v.exp_fb = 0; v.exp_pass = 1;
      v.exp_cycles = 1026; v.exp_end_a = 15; v.exp_end_b = 15;
    end else begin
      v.exp_fa = (kind == 1) ? 0 : fa;
      v.exp_fb = (kind == 1) ? 0 : fb;
      p = v.exp_fa * 16 + v.exp_fb;
      v.exp_err    = Stop ? 1 : err_full;
      v.exp_seen   = 1;
      v.exp_pass   = 0;
      v.exp_cycles = Stop ? 4 * p + 6 : 1026;
      v.exp_end_a  = Stop ? v.exp_fa : 15;
      v.exp_end_b  = Stop ? v.exp_fb : 15;
    end
    return v;
  endfunction

  // Start a sweep, follow it to done, check timing, pair order and results.
  task automatic run_sweep(input int idx, input vec_t v);
    int         cyc;
    int         hold;
    int         oerr;
    bit         first;
    logic [7:0] prev;
    logic [7:0] cur;
    fault_kind = v.kind; fpa = 4'(v.fa); fpb = 4'(v.fb); fbad = 4'(v.bad);
    mif.start = 1'b1;
    cyc = 1;
    step();
    mif.start = 1'b0;
    cyc = 2;
    chk($sformatf("v%0d start_busy", idx), int'(mif.busy), 1);
    chk($sformatf("v%0d start_err_clr", idx), int'(mif.err_count), 0);
    chk($sformatf("v%0d start_seen_clr", idx), int'(mif.fail_seen), 0);
    chk($sformatf("v%0d start_pass_clr", idx), int'(mif.pass), 0);
    first = 1'b1; hold = 0; oerr = 0; prev = 8'd0;
    while (!mif.done && cyc < 1100) begin
      if (mif.busy) begin
        cur = {mif.cmp_a, mif.cmp_b};
        if (first) begin
          first = 1'b0;
          if (cur != 8'd0) oerr++;
          prev = cur; hold = 1;
        end else if (cur == prev) begin
          hold++;
        end else begin
          if (cur != prev + 8'd1 || hold != 4) oerr++;
          prev = cur; hold = 1;
        end
      end else begin
        oerr++;
      end
      mif.start = (v.inj && cyc == 300);
      step();
      mif.start = 1'b0;
      cyc++;
    end
    chk($sformatf("v%0d done_cycle", idx), cyc, v.exp_cycles);
    chk($sformatf("v%0d pair_order", idx), oerr, 0);
    chk($sformatf("v%0d done_busy", idx), int'(mif.busy), 0);
    chk($sformatf("v%0d err_count", idx), int'(mif.err_count), v.exp_err);
    chk($sformatf("v%0d fail_seen", idx), int'(mif.fail_seen), v.exp_seen);
    chk($sformatf("v%0d fail_a", idx), int'(mif.fail_a), v.exp_fa);
    chk($sformatf("v%0d fail_b", idx), int'(mif.fail_b), v.exp_fb);
    chk($sformatf("v%0d pass", idx), int'(mif.pass), v.exp_pass);
    chk($sformatf("v%0d end_a", idx), int'(mif.cmp_a), v.exp_end_a);
    chk($sformatf("v%0d end_b", idx), int'(mif.cmp_b), v.exp_end_b);
    step();
    chk($sformatf("v%0d done_one_cycle", idx), int'(mif.done), 0);
    step();
    chk($sformatf("v%0d hold_err", idx), int'(mif.err_count), v.exp_err);
    chk($sformatf("v%0d hold_pass", idx), int'(mif.pass), v.exp_pass);
  endtask

  // Run a sweep without checks and stop in the done cycle; returns 0 on timeout.
  task automatic sweep_to_done(output bit ok);
    int cyc;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    cyc = 0;
    while (!mif.done && cyc < 1100) begin
      step();
      cyc++;
    end
    ok = mif.done;
  endtask

  vec_t vecs[6];
  bit   ok;
  int   cnt;
  int   done_seen;

  initial begin
    mif.start = 1'b0;
    vecs[0] = mk(0, 0, 0, 0, 0, 1'b1);
    vecs[1] = mk(1, 0, 0, 0, 16, 1'b0);
    vecs[2] = mk(2, 3, 1, 4'b0010, 1, 1'b0);
    vecs[3] = mk(2, 0, 7, 4'b0001, 1, 1'b0);
    vecs[4] = mk(2, 15, 15, 4'b0000, 1, 1'b0);
    vecs[5] = mk(2, 1, 1, 4'b1001, 1, 1'b0);

    repeat (3) step();
    chk("rst_busy", int'(mif.busy), 0);
    chk("rst_done", int'(mif.done), 0);
    chk("rst_pass", int'(mif.pass), 0);
    chk("rst_err", int'(mif.err_count), 0);
    chk("rst_a", int'(mif.cmp_a), 0);
    chk("rst_b", int'(mif.cmp_b), 0);
    chk("rst_seen", int'(mif.fail_seen), 0);
    rst = 1'b0;
    step();
    chk("idle_stays", int'(mif.busy), 0);

    for (int i = 0; i < 6; i++) run_sweep(i, vecs[i]);

    chk("sat_err", int'(sif.err_count), Stop ? 1 : 7);
    chk("sat_seen", int'(sif.fail_seen), 1);
    chk("sat_pass", int'(sif.pass), 0);

    // Reset mid-sweep at pair (5,9), with start asserted alongside reset.
    fault_kind = Stop ? 0 : 1;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    cnt = 0;
    while (!(mif.cmp_a == 4'd5 && mif.cmp_b == 4'd9) && cnt < 2000) begin
      step();
      cnt++;
    end
    chk("reach_5_9", int'(mif.cmp_a == 4'd5 && mif.cmp_b == 4'd9), 1);
    chk("pre_rst_err", int'(mif.err_count), Stop ? 0 : 6);
    rst = 1'b1;
    mif.start = 1'b1;
    step();
    chk("mid_rst_busy", int'(mif.busy), 0);
    chk("mid_rst_a", int'(mif.cmp_a), 0);
    chk("mid_rst_b", int'(mif.cmp_b), 0);
    chk("mid_rst_err", int'(mif.err_count), 0);
    done_seen = int'(mif.done);
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen += int'(mif.done) + int'(mif.busy);
    end
    chk("rst_hold_no_done", done_seen, 0);
    rst = 1'b0;
    mif.start = 1'b0;
    step();
    chk("rst_start_ignored", int'(mif.busy), 0);
    run_sweep(6, mk(0, 0, 0, 0, 0, 1'b0));

    // Start during the done cycle is ignored.
    fault_kind = 0;
    sweep_to_done(ok);
    chk("sweep_a_done", int'(ok), 1);
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    chk("finish_start_busy", int'(mif.busy), 0);
    step();
    chk("finish_start_ignored", int'(mif.busy), 0);
    chk("finish_pass_held", int'(mif.pass), 1);

    // Start in the cycle right after done is accepted.
    sweep_to_done(ok);
    chk("sweep_b_done", int'(ok), 1);
    step();
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    chk("after_done_start", int'(mif.busy), 1);
    chk("after_done_pass_clr", int'(mif.pass), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compare_sweep_checker.md
Name: compare_sweep_checker

Overview:
- Sequential driver/checker for the 4-bit `compare` unit.
- Generates every operand pair (a,b) on the compare inputs and waits a fixed settle time.
- Samples the compare output and checks it against an internally computed expected code.
- Counts mismatches and records the first failing pair. Used as an on-chip self-test next to the ALU compare path.

Parameters:
- WIDTH, 4, operand width; sweep covers 2^(2*WIDTH) pairs.
- SETTLE_CYCLES, 2, cycles cmp_a/cmp_b are held stable before cmp_out is sampled; legal range 1..15.
- ERR_W, 9, width of err_count; saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep when idle.
- cmp_a  output  WIDTH  operand A driven to compare.
- cmp_b  output  WIDTH  operand B driven to compare.
- cmp_out  input  4  compare result; expected encoding is {1'b0, a>b, a<b, a==b}.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep ends.
- pass  output  1  valid from the done pulse until the next start; 1 when err_count==0.
- err_count  output  ERR_W  number of mismatching pairs in the last or current sweep.
- fail_a  output  WIDTH  A operand of the first mismatch.
- fail_b  output  WIDTH  B operand of the first mismatch.
- fail_seen  output  1  set when the first mismatch is captured.

Behaviour:
- Reset (clk edge with rst=1) clears everything: state=IDLE, cmp_a=0, cmp_b=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, fail_seen=0, settle counter=0. rst overrides start on the same edge.
- States: IDLE, DRIVE, SETTLE, CHECK, FINISH.
- IDLE:
  - start=1 -> DRIVE.
  - On that edge: cmp_a=0, cmp_b=0, err_count=0, fail_seen=0, fail_a=0, fail_b=0, pass=0, busy=1.
  - start while busy is ignored.
- DRIVE: load settle counter with SETTLE_CYCLES-1 -> SETTLE.
- SETTLE: decrement each cycle; at 0 -> CHECK.
- CHECK: compare cmp_out against expected. Expected is computed combinationally from the registered cmp_a/cmp_b as unsigned magnitudes, bit3=0.
  - On mismatch:
    - err_count increments, saturating at 2^ERR_W-1.
    - If fail_seen=0: capture fail_a=cmp_a, fail_b=cmp_b, set fail_seen=1.
  - Advance the pair: cmp_b increments. When cmp_b wraps from all-ones to 0, cmp_a also increments.
  - If the pair checked was (all-ones, all-ones) -> FINISH. Otherwise -> DRIVE.
  - cmp_a/cmp_b do not advance past the final pair; they stay at all-ones.
- FINISH: done=1 for exactly one cycle, busy=0, pass=(err_count==0) -> IDLE.
- Timing: a pair is held for SETTLE_CYCLES+2 cycles (DRIVE + SETTLE + CHECK).
  - Full sweep at WIDTH=4, SETTLE_CYCLES=2: 256*4 cycles, plus 1 FINISH cycle, plus 1 start-to-DRIVE cycle. done asserts 1026 cycles after the start edge.
- Pair order: (0,0),(0,1),…,(0,15),(1,0),…,(15,15).
- Reset mid-sweep: abort immediately to the reset values above; no done pulse.
- A start on the same edge as FINISH is ignored. A start in the cycle after done is accepted.
- Results (err_count, fail_*, pass) hold in IDLE until the next accepted start.

Optional Feature:
- Macro: COMPARE_SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch in CHECK goes directly to FINISH. err_count=1, pass=0, and the failing pair is captured.
  - cmp_a/cmp_b stay on the failing pair (no advance), so the fault is observable at the compare pins.
- Undefined: the full sweep always runs, as described above.

Test Plan:
- Correct compare model, start pulse:
  - -> busy=1 for the whole sweep; done pulses 1026 cycles after start.
  - -> err_count=0, pass=1, fail_seen=0.
- Model with eq stuck at 0:
  - -> err_count=16 (every a==b pair); fail_a=0, fail_b=0, fail_seen=1, pass=0.
- Model returning a<b for (a=3,b=1) only:
  - -> err_count=1, fail_a=3, fail_b=1.
  - With COMPARE_SWEEP_STOP_ON_FAIL_EN: done pulses early; cmp_a=3, cmp_b=1 held.
- Spot checks with a correct model:
  - (0,7) expected 4'b0010; (1,1) expected 4'b0001; (3,1) expected 4'b0100; all accepted.
- rst asserted mid-sweep at pair (5,9):
  - -> next cycle busy=0, cmp_a=0, cmp_b=0, err_count=0, no done.
  - A subsequent start runs a full clean sweep.
- start pulsed while busy and again coincident with rst:
  - -> both ignored; sweep timing unchanged, or held in reset, respectively.
